// File: rtl/sys_array_feeder_pkg.sv
// Shared types and constants for the 2x2 systolic array feeder.
package sys_array_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FEED = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } feeder_state_t;

  localparam int DATA_W_DEF  = 32;
  localparam int RES_W       = 2 * DATA_W_DEF;
  localparam int FEED_CYCLES = 3;

  // Element slot within a packed 2x2 matrix: slot k occupies [k*DATA_W +: DATA_W].
  localparam int IDX_00 = 0;
  localparam int IDX_01 = 1;
  localparam int IDX_10 = 2;
  localparam int IDX_11 = 3;

endpackage

// File: rtl/sys_array_feeder_if.sv
// Operand and result valid/ready channels of the feeder.
// Handshake rule for both channels: a transfer happens on a rising edge where
// valid and ready are both high; valid, once raised, holds its payload stable
// until that transfer.
interface sys_array_feeder_if #(
  parameter int DATA_W = 32
);
  logic                  in_valid;
  logic                  in_ready;
  logic [4*DATA_W-1:0]   mat_a;
  logic [4*DATA_W-1:0]   mat_b;

  logic                  res_valid;
  logic                  res_ready;
  logic [2*DATA_W-1:0]   res_00;
  logic [2*DATA_W-1:0]   res_01;
  logic [2*DATA_W-1:0]   res_10;
  logic [2*DATA_W-1:0]   res_11;
  logic [3:0]            res_carry;
  logic                  res_err;

  modport master (
    output in_valid, mat_a, mat_b, res_ready,
    input  in_ready, res_valid, res_00, res_01, res_10, res_11, res_carry, res_err
  );

  modport slave (
    input  in_valid, mat_a, mat_b, res_ready,
    output in_ready, res_valid, res_00, res_01, res_10, res_11, res_carry, res_err
  );
endinterface

// File: rtl/sys_array_feeder_skew.sv
// Diagonal skew mux: picks the row/column stream values for one feed cycle.
module sys_array_skew
  import sys_array_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                feeding,
  input  logic [1:0]          cnt,
  input  logic [4*DATA_W-1:0] a,
  input  logic [4*DATA_W-1:0] b,
  output logic [DATA_W-1:0]   row0,
  output logic [DATA_W-1:0]   row1,
  output logic [DATA_W-1:0]   col0,
  output logic [DATA_W-1:0]   col1
);

  always_comb begin
    row0 = '0;
    row1 = '0;
    col0 = '0;
    col1 = '0;
    if (feeding) begin
      case (cnt)
        2'd0: begin
          row0 = a[IDX_00*DATA_W +: DATA_W];
          col0 = b[IDX_00*DATA_W +: DATA_W];
        end
        2'd1: begin
          row0 = a[IDX_01*DATA_W +: DATA_W];
          row1 = a[IDX_10*DATA_W +: DATA_W];
          col0 = b[IDX_10*DATA_W +: DATA_W];
          col1 = b[IDX_01*DATA_W +: DATA_W];
        end
        2'd2: begin
          row1 = a[IDX_11*DATA_W +: DATA_W];
          col1 = b[IDX_11*DATA_W +: DATA_W];
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/sys_array_feeder.sv
// Feeds one operand pair into the 2x2 systolic array, waits for done (or a
// timeout) and holds the captured results for the downstream consumer.
module sys_array_feeder
  import sys_array_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int TIMEOUT = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  sys_array_feeder_if.slave    bus,
  output logic                 load_in,
  output logic [DATA_W-1:0]    row_in_row0,
  output logic [DATA_W-1:0]    row_in_row1,
  output logic [DATA_W-1:0]    col_in_col0,
  output logic [DATA_W-1:0]    col_in_col1,
  input  logic [2*DATA_W-1:0]  result_row00,
  input  logic [2*DATA_W-1:0]  result_row01,
  input  logic [2*DATA_W-1:0]  result_row10,
  input  logic [2*DATA_W-1:0]  result_row11,
  input  logic                 carry_00,
  input  logic                 carry_01,
  input  logic                 carry_10,
  input  logic                 carry_11,
  input  logic                 done,
  output feeder_state_t        state
);

  localparam int              CNT_W     = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [1:0]      FEED_LAST = 2'(FEED_CYCLES - 1);

  logic [4*DATA_W-1:0] a_q, b_q;
  logic [1:0]          feed_cnt;
  logic [CNT_W-1:0]    wait_cnt;

  // Stream values for the *next* cycle, so the registered streams line up
  // with load_in and feed_cnt.
  logic                sk_feeding;
  logic [1:0]          sk_cnt;
  logic [4*DATA_W-1:0] sk_a, sk_b;
  logic [DATA_W-1:0]   sk_row0, sk_row1, sk_col0, sk_col1;

  always_comb begin
    sk_feeding = 1'b0;
    sk_cnt     = '0;
    sk_a       = a_q;
    sk_b       = b_q;
    if (state == IDLE && bus.in_valid && bus.in_ready) begin
      sk_feeding = 1'b1;
      sk_a       = bus.mat_a;
      sk_b       = bus.mat_b;
    end else if (state == FEED && feed_cnt != FEED_LAST) begin
      sk_feeding = 1'b1;
      sk_cnt     = feed_cnt + 2'd1;
    end
  end

  sys_array_skew #(.DATA_W(DATA_W)) u_skew (
    .feeding (sk_feeding),
    .cnt     (sk_cnt),
    .a       (sk_a),
    .b       (sk_b),
    .row0    (sk_row0),
    .row1    (sk_row1),
    .col0    (sk_col0),
    .col1    (sk_col1)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      a_q           <= '0;
      b_q           <= '0;
      feed_cnt      <= '0;
      wait_cnt      <= '0;
      load_in       <= 1'b0;
      row_in_row0   <= '0;
      row_in_row1   <= '0;
      col_in_col0   <= '0;
      col_in_col1   <= '0;
      bus.in_ready  <= 1'b0;
      bus.res_valid <= 1'b0;
      bus.res_00    <= '0;
      bus.res_01    <= '0;
      bus.res_10    <= '0;
      bus.res_11    <= '0;
      bus.res_carry <= '0;
      bus.res_err   <= 1'b0;
    end else begin
      load_in     <= sk_feeding;
      row_in_row0 <= sk_row0;
      row_in_row1 <= sk_row1;
      col_in_col0 <= sk_col0;
      col_in_col1 <= sk_col1;
      case (state)
        IDLE: begin
          if (bus.in_valid && bus.in_ready) begin
            a_q          <= bus.mat_a;
            b_q          <= bus.mat_b;
            feed_cnt     <= '0;
            bus.in_ready <= 1'b0;
            state        <= FEED;
          end else begin
            bus.in_ready <= 1'b1;
          end
        end
        FEED: begin
          if (feed_cnt == FEED_LAST) begin
            wait_cnt <= '0;
            state    <= WAIT;
          end else begin
            feed_cnt <= feed_cnt + 2'd1;
          end
        end
        WAIT: begin
          // done takes priority over an expiry in the same cycle
          if (done) begin
            bus.res_00    <= result_row00;
            bus.res_01    <= result_row01;
            bus.res_10    <= result_row10;
            bus.res_11    <= result_row11;
            bus.res_carry <= {carry_11, carry_10, carry_01, carry_00};
            bus.res_err   <= 1'b0;
            bus.res_valid <= 1'b1;
            state         <= HOLD;
          end else if (wait_cnt == WAIT_LAST) begin
            bus.res_00    <= '0;
            bus.res_01    <= '0;
            bus.res_10    <= '0;
            bus.res_11    <= '0;
            bus.res_carry <= '0;
            bus.res_err   <= 1'b1;
            bus.res_valid <= 1'b1;
            state         <= HOLD;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        HOLD: begin
          if (bus.res_valid && bus.res_ready) begin
            bus.res_valid <= 1'b0;
            bus.in_ready  <= 1'b1;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
